fft_iter_ctrl_param: RTL and testbench

//  Parametrised sequencer for the in-place iterative radix-2 FFT core. Steps LOG2N layers x 2^(LOG2N-1)

---
 rtl/fft_iter_ctrl_param.sv | 171 +++++++++++++++++
 tb/tb_fft_iter_ctrl_param.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/fft_iter_ctrl_param.sv
`default_nettype none
// ============================================================================
// Module      : fft_iter_ctrl_param
// Description : Sequencer for an in-place iterative radix-2 FFT core; walks
//               LOG2N layers of 2^(LOG2N-1) butterflies with programmable
//               RAM-read and butterfly latencies.
// Revision    : 1.0 - initial release
// ============================================================================
module fft_iter_ctrl_param #(
    parameter int LOG2N  = 5,
    parameter int RD_LAT = 1,
    parameter int BF_LAT = 1,
    parameter int LAY_W  = 3,
    parameter int BUT_W  = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic             START,
    input  logic             ABORT,
    input  logic             INV,
    output logic             ADDR_EN,
    output logic             BUT_STROB,
    output logic             WR,
    output logic             LAY_EN,
    output logic             FIRST,
    output logic             LAST,
    output logic [LAY_W-1:0] LAY_IDX,
    output logic [BUT_W-1:0] BUT_IDX,
    output logic             INV_Q,
    output logic             BUSY,
    output logic             DONE
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ADDR    = 3'd1,
        S_RD_WAIT = 3'd2,
        S_RD      = 3'd3,
        S_BF_WAIT = 3'd4,
        S_WR      = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    localparam logic [LAY_W-1:0] C_LAY_LAST = LAY_W'(LOG2N - 1);
    localparam logic [BUT_W-1:0] C_BUT_LAST = '1;
    localparam logic [3:0]       C_RD_LAST  = (RD_LAT > 0) ? 4'(RD_LAT - 1) : 4'd0;
    localparam logic [3:0]       C_BF_LAST  = (BF_LAT > 0) ? 4'(BF_LAT - 1) : 4'd0;

    state_t           state_q, state_d;
    logic [LAY_W-1:0] lay_q, lay_d;
    logic [BUT_W-1:0] but_q, but_d;
    logic [3:0]       wait_q, wait_d;
    logic             inv_q, inv_d;
    logic             busy_q, busy_d;
    logic             first_q, first_d;
    logic             last_q, last_d;
    logic             last_but;
    logic             in_run;

    always_comb begin
        state_d  = state_q;
        lay_d    = lay_q;
        but_d    = but_q;
        wait_d   = wait_q;
        inv_d    = inv_q;
        last_but = (lay_q == C_LAY_LAST) && (but_q == C_BUT_LAST);
        in_run   = (state_q != S_IDLE) && (state_q != S_DONE);
        if (EN) begin
            if (ABORT && in_run) begin
                state_d = S_IDLE;
                lay_d   = '0;
                but_d   = '0;
                wait_d  = '0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (START && !ABORT) begin
                            state_d = S_ADDR;
                            inv_d   = INV;
                        end
                    end
                    S_ADDR: begin
                        state_d = (RD_LAT == 0) ? S_RD : S_RD_WAIT;
                        wait_d  = '0;
                    end
                    S_RD_WAIT: begin
                        if (wait_q == C_RD_LAST) begin
                            state_d = S_RD;
                            wait_d  = '0;
                        end else begin
                            wait_d = wait_q + 4'd1;
                        end
                    end
                    S_RD: begin
                        state_d = (BF_LAT == 0) ? S_WR : S_BF_WAIT;
                        wait_d  = '0;
                    end
                    S_BF_WAIT: begin
                        if (wait_q == C_BF_LAST) begin
                            state_d = S_WR;
                            wait_d  = '0;
                        end else begin
                            wait_d = wait_q + 4'd1;
                        end
                    end
                    S_WR: begin
                        // Final write keeps the indices parked on the last butterfly.
                        if (last_but) begin
                            state_d = S_DONE;
                        end else begin
                            state_d = S_ADDR;
                            but_d   = but_q + BUT_W'(1);
                            if (but_q == C_BUT_LAST) begin
                                lay_d = lay_q + LAY_W'(1);
                            end
                        end
                    end
                    S_DONE: begin
                        state_d = S_IDLE;
                        lay_d   = '0;
                        but_d   = '0;
                    end
                    default: begin
                        state_d = S_IDLE;
                    end
                endcase
            end
        end
        busy_d  = (state_d != S_IDLE) && (state_d != S_DONE);
        first_d = busy_d && (lay_d == '0);
        last_d  = busy_d && (lay_d == C_LAY_LAST);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            lay_q   <= '0;
            but_q   <= '0;
            wait_q  <= '0;
            inv_q   <= 1'b0;
            busy_q  <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lay_q   <= lay_d;
            but_q   <= but_d;
            wait_q  <= wait_d;
            inv_q   <= inv_d;
            busy_q  <= busy_d;
            first_q <= first_d;
            last_q  <= last_d;
        end
    end

    // Strobes are state decodes qualified by EN so a stalled strobe reissues.
    assign ADDR_EN   = EN && (state_q == S_ADDR);
    assign BUT_STROB = EN && (state_q == S_RD);
    assign WR        = EN && (state_q == S_WR) && !ABORT;
    assign DONE      = EN && (state_q == S_DONE);
    assign LAY_EN    = ADDR_EN && (but_q == '0) && (lay_q != '0);
    assign FIRST     = first_q;
    assign LAST      = last_q;
    assign LAY_IDX   = lay_q;
    assign BUT_IDX   = but_q;
    assign INV_Q     = inv_q;
    assign BUSY      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_fft_iter_ctrl_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_fft_iter_ctrl_param
// Description : Three parameter sets driven in lockstep and compared every
//               cycle against a butterfly-count/phase reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fft_iter_ctrl_param;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic RST   = 1'b1;
    logic EN    = 1'b0;
    logic START = 1'b0;
    logic ABORT = 1'b0;
    logic INV   = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    int p_l[3]  = '{3, 3, 5};
    int p_rd[3] = '{1, 0, 1};
    int p_bf[3] = '{1, 3, 1};

    // Model state: 0 idle, 1 running, 2 done cycle
    int m_st[3], m_b[3], m_pos[3], m_inv[3];
    int done_at[3];
    int iter;

    logic       o_addr[3], o_strob[3], o_wr[3], o_layen[3], o_first[3];
    logic       o_last[3], o_invq[3], o_busy[3], o_done[3];
    logic [7:0] o_lay[3], o_but[3];
    logic [1:0] lay0, but0, lay1, but1;
    logic [2:0] lay2;
    logic [3:0] but2;

    always_comb begin
        o_lay[0] = {6'd0, lay0};
        o_but[0] = {6'd0, but0};
        o_lay[1] = {6'd0, lay1};
        o_but[1] = {6'd0, but1};
        o_lay[2] = {5'd0, lay2};
        o_but[2] = {4'd0, but2};
    end

    fft_iter_ctrl_param #(.LOG2N(3), .RD_LAT(1), .BF_LAT(1), .LAY_W(2), .BUT_W(2)) u0 (
        .CLK(CLK), .RST(RST), .EN(EN), .START(START), .ABORT(ABORT), .INV(INV),
        .ADDR_EN(o_addr[0]), .BUT_STROB(o_strob[0]), .WR(o_wr[0]), .LAY_EN(o_layen[0]),
        .FIRST(o_first[0]), .LAST(o_last[0]), .LAY_IDX(lay0), .BUT_IDX(but0),
        .INV_Q(o_invq[0]), .BUSY(o_busy[0]), .DONE(o_done[0]));

    fft_iter_ctrl_param #(.LOG2N(3), .RD_LAT(0), .BF_LAT(3), .LAY_W(2), .BUT_W(2)) u1 (
        .CLK(CLK), .RST(RST), .EN(EN), .START(START), .ABORT(ABORT), .INV(INV),
        .ADDR_EN(o_addr[1]), .BUT_STROB(o_strob[1]), .WR(o_wr[1]), .LAY_EN(o_layen[1]),
        .FIRST(o_first[1]), .LAST(o_last[1]), .LAY_IDX(lay1), .BUT_IDX(but1),
        .INV_Q(o_invq[1]), .BUSY(o_busy[1]), .DONE(o_done[1]));

    fft_iter_ctrl_param #(.LOG2N(5), .RD_LAT(1), .BF_LAT(1), .LAY_W(3), .BUT_W(4)) u2 (
        .CLK(CLK), .RST(RST), .EN(EN), .START(START), .ABORT(ABORT), .INV(INV),
        .ADDR_EN(o_addr[2]), .BUT_STROB(o_strob[2]), .WR(o_wr[2]), .LAY_EN(o_layen[2]),
        .FIRST(o_first[2]), .LAST(o_last[2]), .LAY_IDX(lay2), .BUT_IDX(but2),
        .INV_Q(o_invq[2]), .BUSY(o_busy[2]), .DONE(o_done[2]));

    task automatic check(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s at t=%0t: got %0d expected %0d", tag, $time, act, exp);
        end
    endtask

    task automatic check_outputs();
        for (int d = 0; d < 3; d++) begin
            int nb   = 1 << (p_l[d] - 1);
            int per  = 3 + p_rd[d] + p_bf[d];
            int run  = (m_st[d] == 1) ? 1 : 0;
            int en   = EN ? 1 : 0;
            int lay  = (m_st[d] == 0) ? 0 : m_b[d] / nb;
            int but  = (m_st[d] == 0) ? 0 : m_b[d] % nb;
            int eaddr = (run == 1 && m_pos[d] == 0 && en == 1) ? 1 : 0;
            check($sformatf("u%0d.busy", d), int'(o_busy[d]), run);
            check($sformatf("u%0d.addr_en", d), int'(o_addr[d]), eaddr);
            check($sformatf("u%0d.but_strob", d), int'(o_strob[d]),
                  (run == 1 && m_pos[d] == 1 + p_rd[d] && en == 1) ? 1 : 0);
            check($sformatf("u%0d.wr", d), int'(o_wr[d]),
                  (run == 1 && m_pos[d] == per - 1 && en == 1 && !ABORT) ? 1 : 0);
            check($sformatf("u%0d.done", d), int'(o_done[d]), (m_st[d] == 2 && en == 1) ? 1 : 0);
            check($sformatf("u%0d.lay_en", d), int'(o_layen[d]),
                  (eaddr == 1 && but == 0 && lay != 0) ? 1 : 0);
            check($sformatf("u%0d.lay_idx", d), int'(o_lay[d]), lay);
            check($sformatf("u%0d.but_idx", d), int'(o_but[d]), but);
            check($sformatf("u%0d.first", d), int'(o_first[d]), (run == 1 && lay == 0) ? 1 : 0);
            check($sformatf("u%0d.last", d), int'(o_last[d]), (run == 1 && lay == p_l[d] - 1) ? 1 : 0);
            check($sformatf("u%0d.inv_q", d), int'(o_invq[d]), m_inv[d]);
        end
    endtask

    task automatic model_step();
        for (int d = 0; d < 3; d++) begin
            int nb  = 1 << (p_l[d] - 1);
            int per = 3 + p_rd[d] + p_bf[d];
            if (RST) begin
                m_st[d] = 0; m_b[d] = 0; m_pos[d] = 0; m_inv[d] = 0;
            end else if (EN) begin
                if (m_st[d] == 0) begin
                    if (START && !ABORT) begin
                        m_st[d] = 1; m_b[d] = 0; m_pos[d] = 0; m_inv[d] = INV ? 1 : 0;
                    end
                end else if (m_st[d] == 1) begin
                    if (ABORT) begin
                        m_st[d] = 0; m_b[d] = 0; m_pos[d] = 0;
                    end else if (m_pos[d] == per - 1) begin
                        if (m_b[d] == nb * p_l[d] - 1) m_st[d] = 2;
                        else begin
                            m_b[d]++;
                            m_pos[d] = 0;
                        end
                    end else begin
                        m_pos[d]++;
                    end
                end else begin
                    m_st[d] = 0; m_b[d] = 0; m_pos[d] = 0;
                end
            end
        end
    endtask

    task automatic cycle(input bit rst, input bit en, input bit start, input bit abort, input bit inv);
        @(negedge CLK);
        RST = rst; EN = en; START = start; ABORT = abort; INV = inv;
        #1;
        check_outputs();
        for (int d = 0; d < 3; d++)
            if (o_done[d] && done_at[d] < 0) done_at[d] = iter;
        model_step();
    endtask

    task automatic run_directed(input int stall_from, input int stall_len, input int abort_at,
                                input int n_iter, input bit inv);
        for (int d = 0; d < 3; d++) done_at[d] = -1;
        iter = -1;
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < n_iter; k++) begin
            iter = k;
            cycle(1'b0, !(k >= stall_from && k < stall_from + stall_len), k == 0, k == abort_at,
                  (k > 100) ? ~inv : inv);
        end
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            m_st[d] = 0; m_b[d] = 0; m_pos[d] = 0; m_inv[d] = 0; done_at[d] = -1;
        end
        iter = -1;

        run_directed(100000, 0, -1, 420, 1'b0);
        check("plain.u0.done_cycle", done_at[0], 61);
        check("plain.u1.done_cycle", done_at[1], 73);
        check("plain.u2.done_cycle", done_at[2], 401);

        run_directed(29, 7, -1, 420, 1'b1);
        check("stall.u0.done_cycle", done_at[0], 68);
        check("stall.u1.done_cycle", done_at[1], 80);
        check("stall.u2.done_cycle", done_at[2], 408);

        run_directed(100000, 0, 58, 70, 1'b1);
        check("abort.u0.no_done", done_at[0], -1);
        run_directed(100000, 0, -1, 80, 1'b0);
        check("after_abort.u0.done_cycle", done_at[0], 61);

        iter = -1;
        for (int k = 0; k < 8000; k++) begin
            cycle(($urandom % 700) == 0, ($urandom % 8) != 0, ($urandom % 6) == 0,
                  ($urandom % 1500) == 0, ($urandom % 2) == 1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
